irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Interrupt front-end wrapped around the 4-to-2 priority encoder.
- Synchronises four asynchronous request lines, edge-detects them, and latches edges into a pending register. Applies a software mask and drives the masked vector to the encoder input.
- Consumes the encoder's index/valid result and presents one interrupt at a time to the CPU side with a req/ack handshake. The acknowledged source's pending bit is cleared on ack.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per irq_in bit; legal range 2..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- irq_in  input  4  asynchronous interrupt sources; bit 3 has highest priority; rising-edge sensitive.
- mask_we  input  1  mask register write strobe.
- mask_wdata  input  4  new mask value; 1 = source masked.
- pe_d  output  4  to encoder d input: pending & ~mask, combinational from registers.
- pe_y  input  2  encoder encoded index.
- pe_valid  input  1  encoder valid flag.
- irq_req  output  1  interrupt request to CPU side.
- irq_id  output  2  index of the requested source; valid while irq_req=1.
- irq_ack  input  1  CPU acknowledge; sampled on clk.
- pending  output  4  raw pending register, unmasked, for status readback.
- mask  output  4  current mask register.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, edge-detect history, pending, mask, irq_id and irq_req go to 0. FSM goes to IDLE.
- Synchroniser: per bit, a SYNC_STAGES-deep flop chain. sync_out is the last stage.
- Edge detect: rise[i] = sync_out[i] & ~prev[i]. prev is registered sync_out. A line already high at reset release produces one rise.
- Pending set/clear:
  - pending[i] sets on a clk edge where rise[i]=1.
  - pending[i] clears on the clk edge where the FSM is in ASSERT, irq_ack=1 and irq_id=i.
  - If set and clear hit the same bit in the same cycle, set wins: pending stays 1 and the source is re-raised later.
- Mask: on mask_we=1, mask <= mask_wdata at the clk edge. Masking never clears pending; unmasking a pending bit re-exposes it on pe_d.
- pe_d feeds the combinational encoder. pe_y/pe_valid are treated as same-cycle functions of pe_d.
- FSM states: IDLE, ASSERT, HOLDOFF.
  - IDLE: irq_req=0. If pe_valid=1: irq_id <= pe_y, go to ASSERT. irq_ack is ignored.
  - ASSERT: irq_req=1 and irq_id are held stable; later-arriving higher-priority or mask changes do not retract or change them. If irq_ack=1: clear pending[irq_id], go to HOLDOFF. Otherwise stay.
  - HOLDOFF: irq_req=0 for exactly one cycle, then IDLE. Guarantees the cleared pending bit has propagated before re-arbitration.
- irq_req is a registered output: 1 iff state==ASSERT.
- Latency, irq_in rise (set up before edge 1) to irq_req=1:
  - sync_out high after edge SYNC_STAGES.
  - pending set at edge SYNC_STAGES+1.
  - irq_req high after edge SYNC_STAGES+2 (4 edges at default).
- Ack turnaround: ack sampled at edge k. irq_req low after k. If anything is still pending and unmasked, irq_req is high again after edge k+2 (2 low cycles minimum).
- Reset mid-operation: abandons any outstanding request. irq_req drops immediately and all pending bits are lost.
- A held-high irq_in never re-triggers. A new pending requires a low (synchronised) then high transition.

Test Plan:
- Reset, then pulse irq_in=4'b0100 for 3 cycles -> pending=4'b0100 at edge 3, irq_req=1 with irq_id=2'b10 after edge 4. Hold irq_ack=0 for 10 cycles -> irq_req and irq_id unchanged.
- Simultaneous rises irq_in=4'b1010 -> irq_id=2'b11 first. Ack -> irq_req low 2 cycles, then irq_id=2'b01. Second ack -> pending=0, irq_req stays 0.
- mask=4'b1000 written, then irq_in bit 3 and bit 0 rise -> irq_id=2'b00 only; pending=4'b1001 after ack leaves 4'b1000. Write mask=0 -> irq_id=2'b11 after 2 edges.
- New rise on bit 1 in the exact cycle irq_ack clears bit 1 -> pending[1] stays 1 and irq_req reasserts with irq_id=2'b01 after HOLDOFF.
- irq_in held high continuously after one ack -> no further pending set; pending=0 and irq_req=0 indefinitely.
- Assert rst_n=0 mid-cycle while in ASSERT with pending=4'b0110 -> irq_req, pending and mask read 0 without a clk edge. After release with irq_in=0, irq_req stays 0.

Source files
------------

// File: rtl/irq_pending_ctrl_if.sv
// Interrupt front-end bus: request lines and mask port from the system, the
// encoder loop (pe_d out, pe_y/pe_valid back), the CPU req/ack pair and
// status readback.
//
// Handshake: irq_req/irq_ack. The slave raises irq_req with irq_id and holds
// both stable until irq_ack is sampled high on a rising clk edge while irq_req=1.
// That edge completes the transfer. irq_ack seen while irq_req=0 is ignored.
// No transfer happens on an edge where either signal is low.
interface irq_pending_ctrl_if;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] pe_d;
  logic [1:0] pe_y;
  logic       pe_valid;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [1:0] state_dbg;

  // System / CPU / encoder side.
  modport master (
    output irq_in, mask_we, mask_wdata, pe_y, pe_valid, irq_ack,
    input  pe_d, irq_req, irq_id, pending, mask, state_dbg
  );

  // Interrupt controller side.
  modport slave (
    input  irq_in, mask_we, mask_wdata, pe_y, pe_valid, irq_ack,
    output pe_d, irq_req, irq_id, pending, mask, state_dbg
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller. It synchronises and edge-detects four
// request lines and latches the edges into a pending register. The masked
// pending vector goes to an external priority encoder. The controller
// presents the encoder's choice to the CPU, one interrupt at a time, over
// irq_req/irq_ack. SYNC_STAGES is intended to be 2..4.
module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_out;
  logic [3:0] prev_q;
  logic [3:0] rise;

  logic [3:0] pending_q;
  logic [3:0] mask_q;
  logic       irq_req_q;
  logic [1:0] irq_id_q;

  logic       load_id;
  logic       ack_take;
  logic [3:0] clr_vec;

  // Synchroniser chain for every request line. Stage 0 samples the async pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // History of the synchronised lines, used to find rising edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_out;
    end
  end

  // prev resets to 0, so a line that is already high at reset release gives one rise.
  assign rise = sync_out & ~prev_q;

  // Software mask register. Masking only hides pending bits and never clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (bus.mask_we) begin
      mask_q <= bus.mask_wdata;
    end
  end

  // Pending register. OR-ing rise in after the clear means a fresh edge on
  // the bit being acknowledged wins and is served again later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | rise;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. HOLDOFF is a single cycle. The encoder then sees
  // pending with the acknowledged bit already removed.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (bus.pe_valid) state_n = ST_ASSERT;
      ST_ASSERT:  if (bus.irq_ack)  state_n = ST_HOLDOFF;
      ST_HOLDOFF: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // FSM decode: when to capture the encoder result and which bit the ack clears.
  always_comb begin
    load_id  = 1'b0;
    ack_take = 1'b0;
    clr_vec  = '0;
    case (state)
      ST_IDLE:   load_id  = bus.pe_valid;
      ST_ASSERT: ack_take = bus.irq_ack;
      default: begin
        load_id  = 1'b0;
        ack_take = 1'b0;
      end
    endcase
    if (ack_take) begin
      clr_vec = 4'b0001 << irq_id_q;
    end
  end

  // Registered CPU-side outputs. irq_req mirrors "next state is ASSERT" so it
  // is high exactly while the FSM sits in ASSERT. irq_id is frozen outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      irq_req_q <= (state_n == ST_ASSERT);
      if (load_id) begin
        irq_id_q <= bus.pe_y;
      end
    end
  end

  assign bus.pe_d      = pending_q & ~mask_q;
  assign bus.pending   = pending_q;
  assign bus.mask      = mask_q;
  assign bus.irq_req   = irq_req_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl. Directed scenarios check against
// constants. A randomized run checks against a behavioural model of the
// pending/arbitration rules.
module tb_irq_pending_ctrl;

  localparam int SYNC = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int top_bit(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Behavioural priority encoder closing the loop from pe_d.
  always_comb begin
    bus.pe_valid = |bus.pe_d;
    bus.pe_y     = 2'(top_bit(bus.pe_d));
  end

  // Reference model. irq_in is seen SYNC edges late. A rise sets pending.
  // While idle, the highest unmasked pending source is offered. An ack clears
  // that source unless a new rise lands on it at the same edge. After each
  // ack there is one quiet cycle.
  logic [3:0] m_pend, m_mask, m_sync, m_prev;
  logic       m_req, m_hold;
  logic [1:0] m_id;
  logic [3:0] samp_q[$];

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] rise_v, clr_v, vis;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_sync = 0; m_prev = 0;
      m_req = 0; m_hold = 0; m_id = 0;
      samp_q = {};
      for (int i = 0; i < SYNC; i++) samp_q.push_front(4'b0);
    end else begin
      rise_v = m_sync & ~m_prev;
      clr_v  = (m_req && bus.irq_ack) ? (4'b1 << m_id) : 4'b0;
      vis    = m_pend & ~m_mask;
      if (m_req) begin
        if (bus.irq_ack) begin m_req = 0; m_hold = 1; end
      end else if (m_hold) begin
        m_hold = 0;
      end else if (vis != 0) begin
        m_req = 1;
        m_id  = 2'(top_bit(vis));
      end
      m_pend = (m_pend & ~clr_v) | rise_v;
      if (bus.mask_we) m_mask = bus.mask_wdata;
      m_prev = m_sync;
      samp_q.push_front(bus.irq_in);
      m_sync = samp_q[SYNC-1];
      void'(samp_q.pop_back());
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_once();
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    checks++; if (bus.mask !== 4'b0) begin failures++; $display("FAIL reset_mask got=%b exp=0000", bus.mask); end
    checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.irq_req); end
    checks++; if (bus.irq_id !== 2'b0) begin failures++; $display("FAIL reset_id got=%b exp=00", bus.irq_id); end
    checks++; if (bus.pe_d !== 4'b0) begin failures++; $display("FAIL reset_pe_d got=%b exp=0000", bus.pe_d); end
  endtask

  task automatic test_latency_hold();
    apply_reset();
    bus.irq_in = 4'b0100;
    repeat (3) cyc();
    bus.irq_in = 4'b0000;
    checks++; if (bus.pending !== 4'b0100) begin failures++; $display("FAIL lat_pending_e3 got=%b exp=0100", bus.pending); end
    checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL lat_req_e3 got=%b exp=0", bus.irq_req); end
    cyc();
    checks++; if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL lat_req_e4 got=%b exp=1", bus.irq_req); end
    checks++; if (bus.irq_id !== 2'b10) begin failures++; $display("FAIL lat_id_e4 got=%b exp=10", bus.irq_id); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b10) begin
        failures++; $display("FAIL hold_req_id cyc=%0d got=%b/%b exp=1/10", i, bus.irq_req, bus.irq_id);
      end
    end
    ack_once();
    checks++; if (bus.pending !== 4'b0 || bus.irq_req !== 1'b0) begin
      failures++; $display("FAIL lat_after_ack got=%b/%b exp=0000/0", bus.pending, bus.irq_req);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.irq_in = 4'b1010;
    repeat (4) cyc();
    bus.irq_in = 4'b0000;
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b11) begin
      failures++; $display("FAIL b2b_first got=%b/%b exp=1/11", bus.irq_req, bus.irq_id);
    end
    ack_once();
    checks++; if (bus.irq_req !== 1'b0 || bus.pending !== 4'b0010) begin
      failures++; $display("FAIL b2b_ack1 got=%b/%b exp=0/0010", bus.irq_req, bus.pending);
    end
    cyc();
    checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL b2b_holdoff got=%b exp=0", bus.irq_req); end
    cyc();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b01) begin
      failures++; $display("FAIL b2b_second got=%b/%b exp=1/01", bus.irq_req, bus.irq_id);
    end
    ack_once();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.irq_req !== 1'b0 || bus.pending !== 4'b0) begin
        failures++; $display("FAIL b2b_idle cyc=%0d got=%b/%b exp=0/0000", i, bus.irq_req, bus.pending);
      end
      cyc();
    end
  endtask

  task automatic test_mask();
    apply_reset();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1000;
    cyc();
    bus.mask_we = 1'b0;
    checks++; if (bus.mask !== 4'b1000) begin failures++; $display("FAIL mask_write got=%b exp=1000", bus.mask); end
    bus.irq_in = 4'b1001;
    repeat (4) cyc();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b00) begin
      failures++; $display("FAIL mask_first got=%b/%b exp=1/00", bus.irq_req, bus.irq_id);
    end
    checks++; if (bus.pending !== 4'b1001 || bus.pe_d !== 4'b0001) begin
      failures++; $display("FAIL mask_pend got=%b/%b exp=1001/0001", bus.pending, bus.pe_d);
    end
    ack_once();
    checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL mask_after_ack got=%b exp=1000", bus.pending); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL mask_hidden cyc=%0d got=%b exp=0", i, bus.irq_req); end
    end
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0000;
    cyc();
    bus.mask_we = 1'b0;
    checks++; if (bus.pe_d !== 4'b1000 || bus.irq_req !== 1'b0) begin
      failures++; $display("FAIL unmask_e1 got=%b/%b exp=1000/0", bus.pe_d, bus.irq_req);
    end
    cyc();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b11) begin
      failures++; $display("FAIL unmask_e2 got=%b/%b exp=1/11", bus.irq_req, bus.irq_id);
    end
    bus.irq_in = 4'b0000;
    ack_once();
  endtask

  task automatic test_set_wins();
    apply_reset();
    bus.irq_in = 4'b0010;
    repeat (4) cyc();
    bus.irq_in = 4'b0000;
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b01) begin
      failures++; $display("FAIL sw_first got=%b/%b exp=1/01", bus.irq_req, bus.irq_id);
    end
    repeat (3) cyc();
    bus.irq_in = 4'b0010;
    repeat (2) cyc();
    ack_once();
    checks++; if (bus.pending !== 4'b0010 || bus.irq_req !== 1'b0) begin
      failures++; $display("FAIL sw_collide got=%b/%b exp=0010/0", bus.pending, bus.irq_req);
    end
    cyc();
    checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL sw_holdoff got=%b exp=0", bus.irq_req); end
    cyc();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b01) begin
      failures++; $display("FAIL sw_reraise got=%b/%b exp=1/01", bus.irq_req, bus.irq_id);
    end
    bus.irq_in = 4'b0000;
    ack_once();
  endtask

  task automatic test_held_high();
    apply_reset();
    bus.irq_in = 4'b0001;
    repeat (4) cyc();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'b00) begin
      failures++; $display("FAIL held_first got=%b/%b exp=1/00", bus.irq_req, bus.irq_id);
    end
    ack_once();
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.irq_req !== 1'b0 || bus.pending !== 4'b0) begin
        failures++; $display("FAIL held_quiet cyc=%0d got=%b/%b exp=0/0000", i, bus.irq_req, bus.pending);
      end
      cyc();
    end
    bus.irq_in = 4'b0000;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1000;
    cyc();
    bus.mask_we = 1'b0;
    bus.irq_in = 4'b0110;
    repeat (4) cyc();
    checks++; if (bus.irq_req !== 1'b1 || bus.pending !== 4'b0110 || bus.irq_id !== 2'b10) begin
      failures++; $display("FAIL rm_pre got=%b/%b/%b exp=1/0110/10", bus.irq_req, bus.pending, bus.irq_id);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.irq_req !== 1'b0 || bus.pending !== 4'b0 || bus.mask !== 4'b0) begin
      failures++; $display("FAIL rm_async got=%b/%b/%b exp=0/0000/0000", bus.irq_req, bus.pending, bus.mask);
    end
    bus.irq_in = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL rm_quiet cyc=%0d got=%b exp=0", i, bus.irq_req); end
    end
  endtask

  task automatic test_random();
    logic [3:0] flip;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      flip = '0;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
      bus.irq_in     = bus.irq_in ^ flip;
      bus.irq_ack    = ($urandom_range(0, 2) == 0);
      bus.mask_we    = ($urandom_range(0, 9) == 0);
      bus.mask_wdata = 4'($urandom_range(0, 15));
      cyc();
      checks++; if (bus.pending !== m_pend) begin failures++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, bus.pending, m_pend); end
      checks++; if (bus.mask !== m_mask) begin failures++; $display("FAIL rnd_mask n=%0d got=%b exp=%b", n, bus.mask, m_mask); end
      checks++; if (bus.pe_d !== (m_pend & ~m_mask)) begin failures++; $display("FAIL rnd_pe_d n=%0d got=%b exp=%b", n, bus.pe_d, m_pend & ~m_mask); end
      checks++; if (bus.irq_req !== m_req) begin failures++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, bus.irq_req, m_req); end
      if (m_req) begin
        checks++; if (bus.irq_id !== m_id) begin failures++; $display("FAIL rnd_id n=%0d got=%b exp=%b", n, bus.irq_id, m_id); end
      end
    end
    bus.irq_ack = 1'b0;
    bus.mask_we = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_latency_hold();
    test_back_to_back();
    test_mask();
    test_set_wins();
    test_held_high();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
